// File: rtl/cdb_complete_buffer_pkg.sv
// Shared types and sizing for the complete stage (CDB packet, lane/FU/queue counts).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Defines kept together so the machine width knobs live in one place:
//   `N_WAY    CDB lanes broadcast per cycle
//   `CDB_BITS physical tag width
//   `N_FU     functional-unit result ports feeding the complete stage
//   `CQ_DEPTH completion queue entries (power of 2)

`ifndef N_WAY
`define N_WAY 2
`endif

`ifndef CDB_BITS
`define CDB_BITS 6
`endif

`ifndef N_FU
`define N_FU 4
`endif

`ifndef CQ_DEPTH
`define CQ_DEPTH 8
`endif

package cdb_complete_buffer_pkg;

    localparam int XLEN     = 32;
    localparam int CDB_BITS = `CDB_BITS;

    // One CDB lane / one completion candidate.
    typedef struct packed {
        logic                valid;
        logic [CDB_BITS-1:0] tag;
        logic [XLEN-1:0]     data;
    } CDB_PACKET;

endpackage

// File: rtl/cdb_complete_buffer_cq_select.sv
// Oldest-first selector: compacts the first N_OUT valid candidates into lanes 0..N_OUT-1.
// Latency: purely combinational.
// Backpressure: none; candidates beyond N_OUT are left untaken for the caller to keep.
//
// Ports:
//   cand   candidates ordered oldest first (queue slots from head, then arrivals by FU index)
//   sel    selected packets, contiguous from lane 0, unused lanes all-zero
//   taken  per-candidate flag: this candidate went onto a lane

module cq_select
    import cdb_complete_buffer_pkg::*;
#(
    parameter int N_IN  = 12,
    parameter int N_OUT = 2
) (
    input  CDB_PACKET [N_IN-1:0]  cand,
    output CDB_PACKET [N_OUT-1:0] sel,
    output logic      [N_IN-1:0]  taken
);

    always_comb begin
        int rank;
        sel   = '0;
        taken = '0;
        rank  = 0;
        // rank = number of valid candidates older than this one; it is the
        // lane index the candidate lands on if that lane exists.
        for (int i = 0; i < N_IN; i++) begin
            if (cand[i].valid) begin
                for (int o = 0; o < N_OUT; o++) begin
                    if (rank == o) begin
                        sel[o]   = cand[i];
                        taken[i] = 1'b1;
                    end
                end
                rank++;
            end
        end
    end

endmodule

// File: rtl/cdb_complete_buffer.sv
// Complete stage: queues FU results and broadcasts up to N_CDB per cycle on the CDB.
// Latency: 1 cycle FU handshake -> CDB (0 cycles when CDB_BYPASS_EN is defined).
// Backpressure: fu_ready drops for nonzero-tag FUs once the queue has no room; tag 0 always accepted.
//
// Build option: define CDB_BYPASS_EN for combinational CDB lanes; default is registered lanes.
//
// Ports:
//   clock, reset        clock; synchronous active-high reset
//   branch_haz          mispredict squash: refuse all FUs, drop queue and pending broadcast
//   fu_valid/tag/data   per-FU result offer (tag 0 = no destination)
//   fu_ready            per-FU accept (transfer = fu_valid & fu_ready)
//   cdb_valid/tag/data  CDB lanes, filled contiguously from lane 0
//   occupancy           results still queued (not yet on the CDB)

module cdb_complete_buffer
    import cdb_complete_buffer_pkg::*;
#(
    parameter int N_FU  = `N_FU,
    parameter int N_CDB = `N_WAY,
    parameter int DEPTH = `CQ_DEPTH
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             branch_haz,
    input  logic [N_FU-1:0]                  fu_valid,
    input  logic [N_FU-1:0][CDB_BITS-1:0]    fu_tag,
    input  logic [N_FU-1:0][XLEN-1:0]        fu_data,
    output logic [N_FU-1:0]                  fu_ready,
    output logic [N_CDB-1:0]                 cdb_valid,
    output logic [N_CDB-1:0][CDB_BITS-1:0]   cdb_tag,
    output logic [N_CDB-1:0][XLEN-1:0]       cdb_data,
    output logic [$clog2(DEPTH):0]           occupancy
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int N_IN = DEPTH + N_FU;

    logic [CDB_BITS+XLEN-1:0] q_mem [DEPTH];
    logic [PW-1:0]            head, tail;
    logic [CW-1:0]            count;

    logic [N_FU-1:0]          accept;
    CDB_PACKET [N_IN-1:0]     cand;
    CDB_PACKET [N_CDB-1:0]    sel;
    CDB_PACKET [N_CDB-1:0]    lane_out;
    logic [N_IN-1:0]          taken;

    logic [N_FU-1:0]          wr_en;
    logic [PW-1:0]            wr_idx [N_FU];
    logic [PW-1:0]            head_nxt, tail_nxt;
    logic [CW-1:0]            count_nxt;

    // Admission: FU i may queue only if the nonzero-tag offers from lower
    // indices still leave a free slot. Uses fu_valid of lower FUs, never
    // fu_ready, so there is no combinational loop through the FUs.
    always_comb begin
        int free;
        int pend;
        fu_ready = '0;
        accept   = '0;
        free     = DEPTH - int'(count);
        pend     = 0;
        for (int i = 0; i < N_FU; i++) begin
            fu_ready[i] = !branch_haz && ((fu_tag[i] == '0) || (pend < free));
            accept[i]   = fu_valid[i] && fu_ready[i] && (fu_tag[i] != '0);
            if (fu_valid[i] && (fu_tag[i] != '0)) begin
                pend++;
            end
        end
    end

    // Candidate list in age order: live queue slots from head, then this
    // cycle's accepted arrivals. Tag-0 results are never candidates.
    always_comb begin
        logic [PW-1:0] rd_idx;
        cand   = '0;
        rd_idx = '0;
        for (int s = 0; s < DEPTH; s++) begin
            rd_idx                       = head + PW'(s);
            {cand[s].tag, cand[s].data}  = q_mem[rd_idx];
            cand[s].valid                = (s < int'(count));
        end
        for (int i = 0; i < N_FU; i++) begin
            cand[DEPTH+i].valid = accept[i];
            cand[DEPTH+i].tag   = fu_tag[i];
            cand[DEPTH+i].data  = fu_data[i];
        end
    end

    cq_select #(
        .N_IN  (N_IN),
        .N_OUT (N_CDB)
    ) u_cq_select (
        .cand  (cand),
        .sel   (sel),
        .taken (taken)
    );

    // Queue entries taken for broadcast retire from head; arrivals that did
    // not make it onto a lane are packed in at tail in FU order.
    always_comb begin
        int nq;
        int nw;
        nq    = 0;
        nw    = 0;
        wr_en = '0;
        for (int i = 0; i < N_FU; i++) begin
            wr_idx[i] = '0;
        end
        for (int s = 0; s < DEPTH; s++) begin
            if (taken[s]) begin
                nq++;
            end
        end
        for (int i = 0; i < N_FU; i++) begin
            if (accept[i] && !taken[DEPTH+i]) begin
                wr_en[i]  = 1'b1;
                wr_idx[i] = tail + PW'(nw);
                nw++;
            end
        end
        head_nxt  = head + PW'(nq);
        tail_nxt  = tail + PW'(nw);
        count_nxt = count - CW'(nq) + CW'(nw);
    end

    always_ff @(posedge clock) begin
        if (reset || branch_haz) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_nxt;
            tail  <= tail_nxt;
            count <= count_nxt;
        end
    end

    // Storage needs no reset: slots outside [head, head+count) are ignored.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_FU; i++) begin
            if (wr_en[i]) begin
                q_mem[wr_idx[i]] <= {fu_tag[i], fu_data[i]};
            end
        end
    end

`ifdef CDB_BYPASS_EN
    // Lanes show this cycle's selection directly; a squash or reset blanks them.
    assign lane_out = (reset || branch_haz) ? '0 : sel;
`else
    CDB_PACKET [N_CDB-1:0] lane_q;

    // A squash loads nothing, so the lanes are empty the cycle after it.
    always_ff @(posedge clock) begin
        if (reset || branch_haz) begin
            lane_q <= '0;
        end else begin
            lane_q <= sel;
        end
    end

    assign lane_out = lane_q;
`endif

    always_comb begin
        for (int l = 0; l < N_CDB; l++) begin
            cdb_valid[l] = lane_out[l].valid;
            cdb_tag[l]   = lane_out[l].tag;
            cdb_data[l]  = lane_out[l].data;
        end
    end

    assign occupancy = count;

endmodule

// File: tb/tb_cdb_complete_buffer.sv
// Self-checking bench for cdb_complete_buffer (N_FU=4, N_CDB=2, DEPTH=8).
// Latency: expects lanes one cycle after the handshake, same cycle under CDB_BYPASS_EN.
// Backpressure: expected fu_ready is derived from the scoreboard's queued-entry count.

module tb_cdb_complete_buffer;
    import cdb_complete_buffer_pkg::*;

    localparam int N_FU  = 4;
    localparam int N_CDB = 2;
    localparam int DEPTH = 8;

    typedef logic [N_FU-1:0][CDB_BITS-1:0] tagv_t;
    typedef logic [N_FU-1:0][XLEN-1:0]     datv_t;

    logic                            clock;
    logic                            reset;
    logic                            branch_haz;
    logic [N_FU-1:0]                 fu_valid;
    tagv_t                           fu_tag;
    datv_t                           fu_data;
    logic [N_FU-1:0]                 fu_ready;
    logic [N_CDB-1:0]                cdb_valid;
    logic [N_CDB-1:0][CDB_BITS-1:0]  cdb_tag;
    logic [N_CDB-1:0][XLEN-1:0]      cdb_data;
    logic [$clog2(DEPTH):0]          occupancy;

    int checks = 0;
    int errors = 0;
    int tcount = 0;

    // Scoreboard: accepted nonzero-tag results in broadcast order.
    logic [CDB_BITS+XLEN-1:0] sbq [$];

    cdb_complete_buffer #(
        .N_FU  (N_FU),
        .N_CDB (N_CDB),
        .DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .branch_haz (branch_haz),
        .fu_valid   (fu_valid),
        .fu_tag     (fu_tag),
        .fu_data    (fu_data),
        .fu_ready   (fu_ready),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .occupancy  (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compares every lane against the next scoreboard entries (or zero).
    task automatic check_lanes();
        logic [CDB_BITS+XLEN:0] exp;
        logic [CDB_BITS+XLEN:0] got;
        for (int l = 0; l < N_CDB; l++) begin
            exp = '0;
            if (sbq.size() > 0) begin
                exp = {1'b1, sbq.pop_front()};
            end
            got = {cdb_valid[l], cdb_tag[l], cdb_data[l]};
            check($sformatf("lane%0d", l), 64'(got), 64'(exp));
        end
    endtask

    task automatic step(input logic [N_FU-1:0] v, input tagv_t t, input datv_t d, input logic bh);
        int              free;
        int              pend;
        logic [N_FU-1:0] er;
        @(negedge clock);
        fu_valid   = v;
        fu_tag     = t;
        fu_data    = d;
        branch_haz = bh;
        #1;
        check("occupancy", 64'(occupancy), 64'(sbq.size()));
        free = DEPTH - sbq.size();
        pend = 0;
        for (int i = 0; i < N_FU; i++) begin
            er[i] = !bh && ((t[i] == '0) || (pend < free));
            if (v[i] && (t[i] != '0)) pend++;
        end
        check("fu_ready", 64'(fu_ready), 64'(er));
        for (int i = 0; i < N_FU; i++) begin
            if (v[i] && er[i] && (t[i] != '0)) sbq.push_back({t[i], d[i]});
        end
        if (bh) sbq.delete();
`ifdef CDB_BYPASS_EN
        check_lanes();
`endif
        @(posedge clock);
        #1;
`ifndef CDB_BYPASS_EN
        check_lanes();
`endif
    endtask

    function automatic tagv_t fresh4();
        tagv_t t;
        for (int i = 0; i < N_FU; i++) begin
            tcount = (tcount % 63) + 1;
            t[i]   = CDB_BITS'(tcount);
        end
        return t;
    endfunction

    function automatic datv_t rdata();
        datv_t d;
        for (int i = 0; i < N_FU; i++) d[i] = $urandom();
        return d;
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, '0, '0, 1'b0);
    endtask

    initial begin
        tagv_t t;
        reset      = 1'b1;
        branch_haz = 1'b0;
        fu_valid   = '0;
        fu_tag     = '0;
        fu_data    = '0;

        // Reset held two cycles.
        repeat (2) @(posedge clock);
        #1;
        check("reset cdb_valid", 64'(cdb_valid), 64'd0);
        check("reset occupancy", 64'(occupancy), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        idle(1);

        // Single result on FU2.
        step(4'b0100, {6'd0, 6'd5, 6'd0, 6'd0}, {32'h0, 32'h1234, 32'h0, 32'h0}, 1'b0);
        idle(2);

        // Four results in one cycle: two lanes per cycle, FU order.
        step(4'b1111, {6'd13, 6'd12, 6'd11, 6'd10}, rdata(), 1'b0);
        idle(3);

        // Sustained four per cycle: occupancy climbs to 6, then backpressure; wraps pointers.
        for (int k = 0; k < 8; k++) step(4'b1111, fresh4(), rdata(), 1'b0);
        idle(5);

        // Five queued, then a squash with FU0 offering.
        step(4'b1111, fresh4(), rdata(), 1'b0);
        step(4'b0111, fresh4(), rdata(), 1'b0);
        step(4'b1111, fresh4(), rdata(), 1'b0);
        step(4'b0001, fresh4(), rdata(), 1'b1);
        idle(2);

        // Tag 0 on FU1 while the queue has no room for everyone.
        for (int k = 0; k < 3; k++) step(4'b1111, fresh4(), rdata(), 1'b0);
        for (int k = 0; k < 3; k++) begin
            t    = fresh4();
            t[1] = '0;
            step(4'b1111, t, rdata(), 1'b0);
        end
        idle(5);

        // Reset mid-operation discards queued results.
        step(4'b1111, fresh4(), rdata(), 1'b0);
        step(4'b1111, fresh4(), rdata(), 1'b0);
        @(negedge clock);
        reset    = 1'b1;
        fu_valid = '0;
        @(posedge clock);
        #1;
        check("midreset cdb_valid", 64'(cdb_valid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        sbq.delete();
        idle(2);

        // Random traffic with occasional squashes and tag-0 results.
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N_FU; i++) t[i] = CDB_BITS'($urandom_range(0, 63));
            step(N_FU'($urandom_range(0, 15)), t, rdata(), ($urandom_range(0, 15) == 0));
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
